// File: rtl/multi_result_fifo.sv
// ---------------------------------------------------------------------------
// multi_result_fifo
//
// Result buffer behind the shift-add multiplier controller. Finished
// products arrive as single-cycle pulses with no backpressure. They are
// stored in a DEPTH-entry FIFO and presented downstream on a valid/ready
// handshake. The block also counts multiplications that are still in flight
// and grants start permission upstream only when the buffer is guaranteed
// to have room for every outstanding result.
//
// Handshake: a head entry transfers on every rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_valid and out_data hold their values (rst excepted).
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   op_start     pulse: multiplier accepted an operand pair
//   mul_valid    pulse: mul_product carries a finished result
//   mul_product  finished product, 2*WIDTH bits
//   allow_start  upstream may start an op this cycle (registers only)
//   out_valid    head entry valid (registered)
//   out_data     head entry (registered)
//   out_ready    consumer accepts head this cycle
//   count        FIFO occupancy
//   overflow     sticky: a result was dropped on a full FIFO
//   proto_err    sticky: upstream protocol violation seen
// ---------------------------------------------------------------------------
module multi_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_start,
  input  logic                         mul_valid,
  input  logic [2*WIDTH-1:0]           mul_product,
  output logic                         allow_start,
  output logic                         out_valid,
  output logic [2*WIDTH-1:0]           out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         proto_err
);

  localparam int DW = 2 * WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic          proto_err_q, proto_err_d;

  logic          pop;
  logic          push;
  logic          full;
  logic          drop;
  logic [CW:0]   occupancy;

  always_comb begin
    pop  = out_valid_q && out_ready;
    full = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = mul_valid && (!full || pop);
    drop = mul_valid && full && !pop;

    // Outstanding results plus stored results must never exceed DEPTH.
    occupancy   = {1'b0, count_q} + {1'b0, in_flight_q};
    allow_start = (occupancy < {1'b0, DEPTH_C});

    mem_d = mem_q;
    if (push) begin
      mem_d[wp_q] = mul_product;
    end

    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop  ? rp_q + 1'b1 : rp_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    in_flight_d = in_flight_q;
    if (op_start && !mul_valid && (in_flight_q != DEPTH_C)) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (mul_valid && !op_start && (in_flight_q != '0)) begin
      in_flight_d = in_flight_q - 1'b1;
    end

    overflow_d  = overflow_q | drop;
    proto_err_d = proto_err_q
                | (op_start && !allow_start)
                | (mul_valid && !op_start && (in_flight_q == '0));

    // Output register is loaded from the next-state view of the array so a
    // push into an empty FIFO is visible exactly one cycle later.
    out_valid_d = (count_d != '0);
    out_data_d  = mem_d[rp_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_multi_result_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for multi_result_fifo (WIDTH=4, DEPTH=4).
// Directed stimulus; expected products are queued when a result is issued
// and a negedge monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_multi_result_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 2 * WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          op_start;
  logic          mul_valid;
  logic [DW-1:0] mul_product;
  logic          allow_start;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          proto_err;

  logic [DW-1:0] exp_q[$];
  int            checks;
  int            errors;

  multi_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_start    (op_start),
    .mul_valid   (mul_valid),
    .mul_product (mul_product),
    .allow_start (allow_start),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow),
    .proto_err   (proto_err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_start = 1'b0;
    mul_valid = 1'b0;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  // op_start, then the result on the next cycle; product expected downstream
  task automatic op_pair(input logic [DW-1:0] p);
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    mul_valid = 1'b1;
    mul_product = p;
    exp_q.push_back(p);
    step();
    mul_valid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_output", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("mon_out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    op_start = 1'b0;
    mul_valid = 1'b0;
    mul_product = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_allow_start", 32'(allow_start), 32'd1);

    // 1: single op, result three cycles after start
    out_ready = 1'b1;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    check("t1_allow_inflight", 32'(allow_start), 32'd1);
    repeat (2) step();
    mul_valid = 1'b1;
    mul_product = 8'h2D;
    exp_q.push_back(8'h2D);
    step();
    mul_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data", 32'(out_data), 32'h2D);
    check("t1_allow_stored", 32'(allow_start), 32'd1);
    step();
    check("t1_out_valid_after", 32'(out_valid), 32'd0);
    check("t1_count_after", 32'(count), 32'd0);

    // 2: fill with back-pressure, then drain
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) op_pair(DW'(i));
    check("t2_allow_cnt3", 32'(allow_start), 32'd1);
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    check("t2_allow_reach4", 32'(allow_start), 32'd0);
    mul_valid = 1'b1;
    mul_product = 8'h04;
    exp_q.push_back(8'h04);
    step();
    mul_valid = 1'b0;
    check("t2_count_full", 32'(count), 32'd4);
    check("t2_allow_full", 32'(allow_start), 32'd0);
    check("t2_head_held", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    step();
    check("t2_allow_after_pop", 32'(allow_start), 32'd1);
    check("t2_count_after_pop", 32'(count), 32'd3);
    repeat (3) step();
    check("t2_count_drained", 32'(count), 32'd0);

    // 3: full, simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) op_pair(DW'(8'h10 + i));
    check("t3_count_full", 32'(count), 32'd4);
    out_ready = 1'b1;
    mul_valid = 1'b1;
    mul_product = 8'h14;
    exp_q.push_back(8'h14);
    step();
    mul_valid = 1'b0;
    check("t3_count_same", 32'(count), 32'd4);
    check("t3_overflow", 32'(overflow), 32'd0);
    repeat (4) step();
    check("t3_count_drained", 32'(count), 32'd0);

    // 4: drop on full without pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) op_pair(DW'(8'h20 + i));
    mul_valid = 1'b1;
    mul_product = 8'hAA;
    step();
    mul_valid = 1'b0;
    check("t4_overflow_set", 32'(overflow), 32'd1);
    check("t4_count", 32'(count), 32'd4);
    check("t4_head_held", 32'(out_data), 32'h20);
    step();
    check("t4_overflow_sticky", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    repeat (4) step();
    check("t4_count_drained", 32'(count), 32'd0);
    check("t4_out_valid_drained", 32'(out_valid), 32'd0);
    check("t4_overflow_still", 32'(overflow), 32'd1);

    // 5A: op_start while allow_start is low
    do_reset();
    check("t5_rst_overflow", 32'(overflow), 32'd0);
    check("t5_rst_proto_err", 32'(proto_err), 32'd0);
    op_start = 1'b1;
    repeat (4) step();
    check("t5a_allow_low", 32'(allow_start), 32'd0);
    check("t5a_no_err_yet", 32'(proto_err), 32'd0);
    step();
    op_start = 1'b0;
    check("t5a_proto_err", 32'(proto_err), 32'd1);

    // 5B: result with nothing in flight is flagged but still stored
    do_reset();
    check("t5b_rst_proto_err", 32'(proto_err), 32'd0);
    out_ready = 1'b0;
    mul_valid = 1'b1;
    mul_product = 8'h55;
    exp_q.push_back(8'h55);
    step();
    mul_valid = 1'b0;
    check("t5b_proto_err", 32'(proto_err), 32'd1);
    check("t5b_count", 32'(count), 32'd1);
    check("t5b_out_data", 32'(out_data), 32'h55);
    out_ready = 1'b1;
    step();
    check("t5b_count_drained", 32'(count), 32'd0);

    // 6: reset mid-operation
    out_ready = 1'b0;
    op_pair(8'h31);
    op_pair(8'h32);
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    check("t6_pre_count", 32'(count), 32'd2);
    do_reset();
    check("t6_count", 32'(count), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_data", 32'(out_data), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_proto_err", 32'(proto_err), 32'd0);
    check("t6_allow_start", 32'(allow_start), 32'd1);
    op_pair(8'h77);
    check("t6_post_valid", 32'(out_valid), 32'd1);
    check("t6_post_data", 32'(out_data), 32'h77);
    check("t6_post_proto_err", 32'(proto_err), 32'd0);
    out_ready = 1'b1;
    step();
    check("t6_post_count", 32'(count), 32'd0);

    // final report
    step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
